pipelined_core_param: RTL and testbench

- Parametrised successor to the team's 8-bit three-stage pipelined processor.
- Pipeline: IF -> IF/ID -> ID (decode, register read, jump resolve) -> ID/EX -> EX (ALU with forwarding) -> EX/WB -> register write.
- Data width, register count and PC width are generic. Adds register-register ALU ops, a jump with one-cycle flush, pipeline freeze, a retired-instruction counter and a debug register read port.
- Instruction memory is external, read combinationally in the same cycle.

---
 rtl/pipelined_core_param.sv | 260 ++++++++++++++++++++++++++
 tb/tb_pipelined_core_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_core_param.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_core_param
// Description : Parametrised IF / ID / EX / WB pipelined core. Register-register
//               ALU ops, a JMP resolved in ID with a one-cycle flush, a
//               pipeline freeze, a retired-instruction counter and a debug
//               register read port.
//               Build option PIPE_FWD_EN: defined -> EX operand forwarding,
//               never stalls; undefined -> ID/EX interlock plus WB-to-ID
//               bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_core_param #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int PC_W   = 8
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            Run,
  output logic [PC_W-1:0]                 Imem_Addr,
  input  logic [3+2*REG_AW+DATA_W-1:0]    Imem_Data,
  output logic                            Wb_En,
  output logic [REG_AW-1:0]               Wb_Addr,
  output logic [DATA_W-1:0]               Wb_Data,
  output logic [15:0]                     Retired_Count,
  input  logic [REG_AW-1:0]               Dbg_Addr,
  output logic [DATA_W-1:0]               Dbg_Data
);

  localparam int IW   = 3 + 2*REG_AW + DATA_W;
  localparam int NREG = 1 << REG_AW;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LI   = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;

  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]     CNT_ONE = 16'd1;

`ifdef PIPE_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  // Architectural and pipeline state
  logic [PC_W-1:0]   pc;
  logic [IW-1:0]     ifid_instr;
  logic              ifid_valid;

  logic              idex_valid;
  logic              idex_we;
  logic [2:0]        idex_op;
  logic [REG_AW-1:0] idex_rd;
  logic [REG_AW-1:0] idex_rs;
  logic [DATA_W-1:0] idex_a;
  logic [DATA_W-1:0] idex_b;
  logic [DATA_W-1:0] idex_imm;

  logic              exwb_valid;
  logic              exwb_we;
  logic [REG_AW-1:0] exwb_rd;
  logic [DATA_W-1:0] exwb_data;

  logic [DATA_W-1:0] regs [NREG];
  logic [15:0]       retired;

  // ID stage decode signals
  logic [2:0]        id_op;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs;
  logic [DATA_W-1:0] id_imm;
  logic              id_we;
  logic              id_use_rd;
  logic              id_use_rs;
  logic              id_jmp;
  logic [DATA_W-1:0] id_a;
  logic [DATA_W-1:0] id_b;
  logic [PC_W-1:0]   jmp_target;
  logic              stall;
  logic              take_jmp;

  // EX stage signals
  logic              fwd_a;
  logic              fwd_b;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_res;

  assign id_op  = ifid_instr[IW-1 -: 3];
  assign id_rd  = ifid_instr[IW-4 -: REG_AW];
  assign id_rs  = ifid_instr[IW-4-REG_AW -: REG_AW];
  assign id_imm = ifid_instr[DATA_W-1:0];

  // Writeback is suppressed entirely while the pipeline is frozen
  assign Wb_En         = exwb_valid & exwb_we & Run;
  assign Wb_Addr       = exwb_rd;
  assign Wb_Data       = exwb_data;
  assign Imem_Addr     = pc;
  assign Retired_Count = retired;

  // Jump target: truncate or zero-extend the immediate to the PC width
  generate
    if (PC_W > DATA_W) begin : g_tgt_ext
      assign jmp_target = {{(PC_W-DATA_W){1'b0}}, id_imm};
    end else begin : g_tgt_trunc
      assign jmp_target = id_imm[PC_W-1:0];
    end
  endgenerate

  // Decode: which ops write rd, which read rd/rs, and jump detection
  always_comb begin
    id_we     = 1'b0;
    id_use_rd = 1'b0;
    id_use_rs = 1'b0;
    id_jmp    = 1'b0;
    if (ifid_valid) begin
      case (id_op)
        OP_LI:   id_we = 1'b1;
        OP_ADDI: begin id_we = 1'b1; id_use_rd = 1'b1; end
        OP_ADD,
        OP_SUB:  begin id_we = 1'b1; id_use_rd = 1'b1; id_use_rs = 1'b1; end
        OP_JMP:  id_jmp = 1'b1;
        default: id_we = 1'b0;
      endcase
    end
  end

  // Register read in ID, bypassing a same-cycle writeback
  always_comb begin
    id_a = regs[id_rd];
    id_b = regs[id_rs];
    if (Wb_En && (exwb_rd == id_rd)) id_a = exwb_data;
    if (Wb_En && (exwb_rd == id_rs)) id_b = exwb_data;
  end

  // Interlock (non-forwarding build only): an ID source matches the
  // destination of the writing instruction now in ID/EX. A stall wins
  // over a JMP in ID.
  assign stall = !FWD_ON && idex_valid && idex_we &&
                 ((id_use_rd && (id_rd == idex_rd)) ||
                  (id_use_rs && (id_rs == idex_rd)));
  assign take_jmp = id_jmp && !stall;

  // EX operand forwarding from the EX/WB result (forwarding build only)
  assign fwd_a = FWD_ON && exwb_valid && exwb_we && (exwb_rd == idex_rd);
  assign fwd_b = FWD_ON && exwb_valid && exwb_we && (exwb_rd == idex_rs);
  assign ex_a  = fwd_a ? exwb_data : idex_a;
  assign ex_b  = fwd_b ? exwb_data : idex_b;

  // ALU, modulo 2^DATA_W; unused opcodes produce a value that is never written
  always_comb begin
    ex_res = idex_imm;
    case (idex_op)
      OP_LI:   ex_res = idex_imm;
      OP_ADDI: ex_res = ex_a + idex_imm;
      OP_ADD:  ex_res = ex_a + ex_b;
      OP_SUB:  ex_res = ex_a - ex_b;
      default: ex_res = idex_imm;
    endcase
  end

  // Fetch: PC and IF/ID; hold on stall, redirect and squash on a jump
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc         <= '0;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else if (Run && !stall) begin
      if (take_jmp) begin
        pc         <= jmp_target;
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end else begin
        pc         <= pc + PC_ONE;
        ifid_instr <= Imem_Data;
        ifid_valid <= 1'b1;
      end
    end
  end

  // ID/EX register; a stall injects a bubble that never retires
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idex_valid <= 1'b0;
      idex_we    <= 1'b0;
      idex_op    <= OP_NOP;
      idex_rd    <= '0;
      idex_rs    <= '0;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_imm   <= '0;
    end else if (Run) begin
      if (stall) begin
        idex_valid <= 1'b0;
        idex_we    <= 1'b0;
        idex_op    <= OP_NOP;
        idex_rd    <= '0;
        idex_rs    <= '0;
        idex_a     <= '0;
        idex_b     <= '0;
        idex_imm   <= '0;
      end else begin
        idex_valid <= ifid_valid;
        idex_we    <= id_we;
        idex_op    <= id_op;
        idex_rd    <= id_rd;
        idex_rs    <= id_rs;
        idex_a     <= id_a;
        idex_b     <= id_b;
        idex_imm   <= id_imm;
      end
    end
  end

  // EX/WB register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      exwb_valid <= 1'b0;
      exwb_we    <= 1'b0;
      exwb_rd    <= '0;
      exwb_data  <= '0;
    end else if (Run) begin
      exwb_valid <= idex_valid;
      exwb_we    <= idex_we;
      exwb_rd    <= idex_rd;
      exwb_data  <= ex_res;
    end
  end

  // Register file write at the end of the writeback cycle
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (Wb_En) begin
      regs[exwb_rd] <= exwb_data;
    end
  end

  // Retired counter: every real instruction leaving EX/WB, bubbles excluded
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      retired <= '0;
    end else if (Run && exwb_valid) begin
      retired <= retired + CNT_ONE;
    end
  end

  // Debug read port with write-through of the current writeback
  always_comb begin
    Dbg_Data = regs[Dbg_Addr];
    if (Wb_En && (exwb_rd == Dbg_Addr)) Dbg_Data = exwb_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_core_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_core_param
// Description : Directed, table-driven bench for pipelined_core_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_core_param;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int PC_W   = 8;
  localparam int IW     = 3 + 2*REG_AW + DATA_W;
  localparam int NLOG   = 32;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LI   = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Run = 1'b1;
  logic [PC_W-1:0]   Imem_Addr;
  logic [IW-1:0]     Imem_Data;
  logic              Wb_En;
  logic [REG_AW-1:0] Wb_Addr;
  logic [DATA_W-1:0] Wb_Data;
  logic [15:0]       Retired_Count;
  logic [REG_AW-1:0] Dbg_Addr = '0;
  logic [DATA_W-1:0] Dbg_Data;

  pipelined_core_param #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run),
    .Imem_Addr(Imem_Addr), .Imem_Data(Imem_Data),
    .Wb_En(Wb_En), .Wb_Addr(Wb_Addr), .Wb_Data(Wb_Data),
    .Retired_Count(Retired_Count),
    .Dbg_Addr(Dbg_Addr), .Dbg_Data(Dbg_Data)
  );

  always #5 Clk = ~Clk;

  logic [IW-1:0] imem [0:255];
  assign Imem_Data = imem[Imem_Addr];

  int n_cmp = 0;
  int n_bad = 0;

  int pc_log  [NLOG];
  int en_log  [NLOG];
  int addr_log[NLOG];
  int data_log[NLOG];
  int rc_log  [NLOG];
  int dbg_log [NLOG];

  // Expected timing of the three-instruction hazard program
  int wb_cyc[3];
  int exp_pc[7];
  int wb_addr_exp[3] = '{1, 1, 2};
  int wb_data_exp[3] = '{5, 8, 8};

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] imm;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs, input logic [DATA_W-1:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = '0;
  endtask

  // Reset, then run n cycles from cycle 0; Run is low for cycles [fs, fs+fl)
  task automatic run_prog(input int n, input int fs, input int fl);
    Reset = 1'b0;
    Run   = 1'b1;
    repeat (2) @(negedge Clk);
    for (int c = 0; c < n; c++) begin
      if (c != 0) @(negedge Clk);
      Reset = 1'b1;
      Run   = (c >= fs && c < fs + fl) ? 1'b0 : 1'b1;
      #2;
      pc_log[c]   = int'(Imem_Addr);
      en_log[c]   = int'(Wb_En);
      addr_log[c] = int'(Wb_Addr);
      data_log[c] = int'(Wb_Data);
      rc_log[c]   = int'(Retired_Count);
      dbg_log[c]  = int'(Dbg_Data);
    end
  endtask

  // Compare the logged writebacks of the hazard program, shifted by 'shift' cycles
  task automatic verify_wbs(input string tag, input int n, input int shift);
    int k;
    for (int c = 0; c < n; c++) begin
      k = -1;
      for (int j = 0; j < 3; j++) if (wb_cyc[j] + shift == c) k = j;
      check($sformatf("%s wb_en c%0d", tag, c), en_log[c], (k >= 0) ? 1 : 0);
      if (k >= 0) begin
        check($sformatf("%s wb_addr c%0d", tag, c), addr_log[c], wb_addr_exp[k]);
        check($sformatf("%s wb_data c%0d", tag, c), data_log[c], wb_data_exp[k]);
      end
    end
  endtask

  task automatic load_hazard_prog();
    clear_imem();
    imem[0] = mk(OP_LI,   3'd1, 3'd0, 8'd5);
    imem[1] = mk(OP_ADDI, 3'd1, 3'd0, 8'd3);
    imem[2] = mk(OP_ADD,  3'd2, 3'd1, 8'd0);
  endtask

  initial begin
    int last;
    int r3_writes;

`ifdef PIPE_FWD_EN
    wb_cyc = '{3, 4, 5};
    exp_pc = '{0, 1, 2, 3, 4, 5, 6};
`else
    wb_cyc = '{3, 5, 7};
    exp_pc = '{0, 1, 2, 2, 3, 3, 4};
`endif

    vecs[0] = '{8'h12, 8'h34, OP_LI,   8'h9A, 8'h9A};
    vecs[1] = '{8'h10, 8'h34, OP_ADDI, 8'h05, 8'h15};
    vecs[2] = '{8'hFF, 8'h34, OP_ADDI, 8'h02, 8'h01};
    vecs[3] = '{8'h70, 8'h25, OP_ADD,  8'h00, 8'h95};
    vecs[4] = '{8'hF0, 8'h20, OP_ADD,  8'h00, 8'h10};
    vecs[5] = '{8'h50, 8'h20, OP_SUB,  8'h00, 8'h30};
    vecs[6] = '{8'h00, 8'h01, OP_SUB,  8'h00, 8'hFF};
    vecs[7] = '{8'h33, 8'h44, OP_NOP,  8'h77, 8'h33};
    vecs[8] = '{8'h5A, 8'h11, 3'b110,  8'h22, 8'h5A};
    vecs[9] = '{8'hC3, 8'h11, 3'b111,  8'h22, 8'hC3};

    clear_imem();

    // Reset state
    #1 Reset = 1'b0;
    #2;
    check("reset wb_en",   int'(Wb_En), 0);
    check("reset wb_addr", int'(Wb_Addr), 0);
    check("reset wb_data", int'(Wb_Data), 0);
    check("reset retired", int'(Retired_Count), 0);
    check("reset pc",      int'(Imem_Addr), 0);

    // Hazard program: forwarding or interlock timing depending on build
    load_hazard_prog();
    Dbg_Addr = 3'd2;
    run_prog(12, 99, 0);
    for (int c = 0; c < 7; c++) check($sformatf("hazard pc c%0d", c), pc_log[c], exp_pc[c]);
    verify_wbs("hazard", 12, 0);
    check("hazard retired before last", rc_log[wb_cyc[2]], 2);
    check("hazard retired after last",  rc_log[wb_cyc[2] + 1], 3);
    check("dbg write-through r2", dbg_log[wb_cyc[2]], 8);
    check("dbg r2 before write", dbg_log[wb_cyc[2] - 1], 0);

    // Freeze for 3 cycles starting at cycle 3
    load_hazard_prog();
    run_prog(16, 3, 3);
    for (int c = 3; c <= 6; c++) check($sformatf("freeze pc c%0d", c), pc_log[c], exp_pc[3]);
    verify_wbs("freeze", 16, 3);
    check("freeze retired", rc_log[wb_cyc[2] + 4], 3);

    // Jump flush
    clear_imem();
    imem[0]     = mk(OP_JMP, 3'd0, 3'd0, 8'h10);
    imem[1]     = mk(OP_LI,  3'd3, 3'd0, 8'hFF);
    imem[8'h10] = mk(OP_LI,  3'd4, 3'd0, 8'd7);
    run_prog(10, 99, 0);
    check("jmp pc c0", pc_log[0], 8'h00);
    check("jmp pc c1", pc_log[1], 8'h01);
    check("jmp pc c2", pc_log[2], 8'h10);
    check("jmp pc c3", pc_log[3], 8'h11);
    r3_writes = 0;
    for (int c = 0; c < 10; c++) if (en_log[c] == 1 && addr_log[c] == 3) r3_writes++;
    check("jmp r3 writes", r3_writes, 0);
    check("jmp wb_en c5",   en_log[5], 1);
    check("jmp wb_addr c5", addr_log[5], 4);
    check("jmp wb_data c5", data_log[5], 7);
    check("jmp retired c6", rc_log[6], 2);
    Dbg_Addr = 3'd3; #1;
    check("jmp dbg r3", int'(Dbg_Data), 0);
    Dbg_Addr = 3'd4; #1;
    check("jmp dbg r4", int'(Dbg_Data), 7);

    // Wrap-around sequence
    clear_imem();
    imem[0] = mk(OP_LI,   3'd1, 3'd0, 8'hFF);
    imem[1] = mk(OP_ADDI, 3'd1, 3'd0, 8'h02);
    imem[2] = mk(OP_SUB,  3'd5, 3'd1, 8'h00);
    run_prog(12, 99, 0);
    Dbg_Addr = 3'd1; #1;
    check("wrap r1", int'(Dbg_Data), 8'h01);
    Dbg_Addr = 3'd5; #1;
    check("wrap r5", int'(Dbg_Data), 8'hFF);

    // ALU vector table
    for (int v = 0; v < 10; v++) begin
      clear_imem();
      imem[0] = mk(OP_LI,      3'd6, 3'd0, vecs[v].a);
      imem[1] = mk(OP_LI,      3'd7, 3'd0, vecs[v].b);
      imem[2] = mk(vecs[v].op, 3'd6, 3'd7, vecs[v].imm);
      run_prog(12, 99, 0);
      last = -1;
      for (int c = 0; c < 12; c++) if (en_log[c] == 1 && addr_log[c] == 6) last = data_log[c];
      check($sformatf("vec%0d last wb r6", v), last, int'(vecs[v].exp));
      Dbg_Addr = 3'd6; #1;
      check($sformatf("vec%0d dbg r6", v), int'(Dbg_Data), int'(vecs[v].exp));
    end

    // Reset mid-program at cycle 4
    load_hazard_prog();
    run_prog(4, 99, 0);
    @(negedge Clk);
    Reset = 1'b0;
    #2;
    check("midrst wb_en",   int'(Wb_En), 0);
    check("midrst wb_addr", int'(Wb_Addr), 0);
    check("midrst wb_data", int'(Wb_Data), 0);
    check("midrst retired", int'(Retired_Count), 0);
    check("midrst pc",      int'(Imem_Addr), 0);
    for (int r = 0; r < 8; r++) begin
      Dbg_Addr = 3'(r); #1;
      check($sformatf("midrst dbg r%0d", r), int'(Dbg_Data), 0);
    end
    @(negedge Clk);
    Reset = 1'b1;
    #2;
    check("restart pc c0", int'(Imem_Addr), 0);
    @(negedge Clk);
    #2;
    check("restart pc c1", int'(Imem_Addr), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
